// File: rtl/store_merge_unit.sv
// Purpose: narrows SB/SH/SW stores into a 32-bit word RAM without byte enables (read-modify-write for SB/SH).
// Latency: word store writes 1 cycle after accept; byte/half reads at +1 and writes at +3; rejection flags err at +1.
// Backpressure: req_ready is high only in IDLE with reset released; one store in flight, and a held request waits.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   store handshake; req_addr (byte address), req_data (right-justified), req_size
//                     (00 byte, 01 half, 10 word, 11 reserved)
//   mem_addr          word-aligned RAM address, held from accept through the write
//   mem_rd/mem_rdata  read strobe, with read data returned by synchronous RAM one cycle later
//   mem_wr/mem_wdata  one-cycle write strobe and write data
//   done / err        one-cycle pulses: store committed / request rejected
module store_merge_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic              mem_wr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Only the low half of the store data is ever merged; word data goes straight into wbuf.
    logic [15:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wbuf_q, wbuf_d;

    logic              req_bad;
    logic [31:0]       merged;

    assign req_bad = (req_size == SZ_RSVD)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // Little-endian lane replacement over the word just read back.
    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = data_q[7:0];
                2'd1:    merged[15:8]  = data_q[7:0];
                2'd2:    merged[23:16] = data_q[7:0];
                default: merged[31:24] = data_q[7:0];
            endcase
        end else begin
            if (addr_q[1]) merged[31:16] = data_q;
            else           merged[15:0]  = data_q;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    data_d = req_data[15:0];
                    size_d = req_size;
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else if (req_size == SZ_WORD) begin
                        wbuf_d  = req_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                wbuf_d  = merged;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wbuf_q  <= wbuf_d;
        end
    end

    // Strobes are pure state decodes, so an async reset drops them immediately.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign mem_rd    = (state_q == S_READ);
    assign mem_wr    = (state_q == S_WRITE);
    assign done      = (state_q == S_WRITE);
    assign err       = (state_q == S_ERR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = wbuf_q;

endmodule

// File: tb/tb_store_merge_unit.sv
module tb_store_merge_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    store_merge_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous RAM (64 words) with a preload port used only while the DUT is idle.
    logic [31:0] ram [0:63];
    logic        pl_en;
    int          pl_idx;
    logic [31:0] pl_dat;
    int          wr_cnt;

    always @(posedge clk) begin
        if (pl_en) ram[pl_idx] <= pl_dat;
        else if (mem_wr) ram[int'(mem_addr[7:2])] <= mem_wdata;
        if (mem_rd) mem_rdata <= ram[int'(mem_addr[7:2])];
        if (mem_wr) wr_cnt <= wr_cnt + 1;
    end

    // Reference model state.
    logic [31:0] exp_ram [0:63];
    int          exp_wr;
    int          checks;
    int          errors;

    logic [31:0] nxt_addr;
    logic [31:0] nxt_data;
    logic [1:0]  nxt_size;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] a,
                                                input logic [31:0] d, input logic [1:0] s);
        logic [31:0] mask;
        int          sh;
        if (s == 2'd0) begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'hFF << sh;
            return (old & ~mask) | ((d & 32'hFF) << sh);
        end else if (s == 2'd1) begin
            sh   = 16 * int'(a[1]);
            mask = 32'hFFFF << sh;
            return (old & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    task automatic preload(input int idx, input logic [31:0] v);
        pl_en = 1'b1; pl_idx = idx; pl_dat = v;
        tick();
        pl_en = 1'b0;
        exp_ram[idx] = v;
    endtask

    // Presents one store, checks every cycle until ready returns. With hold set, the
    // request lines switch to nxt_* right after accept and stay valid.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input bit hold);
        bit          bad;
        bit          bh;
        int          lat;
        int          idx;
        logic [31:0] exp_w;
        logic [4:0]  exp_s;
        bad   = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
        bh    = !bad && (s != 2'd2);
        lat   = bh ? 3 : 1;
        idx   = int'(a[7:2]);
        exp_w = merge_model(exp_ram[idx], a, d, s);
        req_valid = 1'b1; req_addr = a; req_data = d; req_size = s;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        tick();
        if (hold) begin
            req_addr = nxt_addr; req_data = nxt_data; req_size = nxt_size;
        end else begin
            req_valid = 1'b0;
            req_data  = $urandom;
        end
        for (int c = 1; c <= lat + 1; c++) begin
            if (c > 1) tick();
            exp_s = {bh && c == 1, !bad && c == lat, !bad && c == lat, bad && c == 1, c == lat + 1};
            chk($sformatf("rd_wr_done_err_rdy a=%h s=%0d c%0d", a, s, c),
                {27'd0, mem_rd, mem_wr, done, err, req_ready}, {27'd0, exp_s});
            if (!bad && c <= lat)
                chk($sformatf("mem_addr c%0d", c), mem_addr, {a[31:2], 2'b00});
            if (!bad && c == lat)
                chk($sformatf("wdata a=%h s=%0d", a, s), mem_wdata, exp_w);
        end
        if (!bad) begin
            exp_ram[idx] = exp_w;
            exp_wr++;
            chk($sformatf("ram word %0d", idx), ram[idx], exp_w);
        end
    endtask

    initial begin
        checks = 0; errors = 0; exp_wr = 0; wr_cnt = 0;
        pl_en = 1'b0; pl_idx = 0; pl_dat = '0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
        nxt_addr = '0; nxt_data = '0; nxt_size = '0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        // Reset state.
        chk("reset strobes", {28'd0, mem_rd, mem_wr, done, err}, 32'd0);
        chk("reset ready", {31'd0, req_ready}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", mem_wdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready after reset", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 64; i++) preload(i, $urandom);

        // Word store.
        do_store(32'h10, 32'hDEADBEEF, 2'd2, 1'b0);
        // Byte store lane 3.
        preload(4, 32'h11223344);
        do_store(32'h13, 32'h000000AB, 2'd0, 1'b0);
        // Half stores, both lanes, upper data bits ignored.
        preload(8, 32'h11223344);
        do_store(32'h22, 32'hFFFF5A5A, 2'd1, 1'b0);
        preload(8, 32'h11223344);
        do_store(32'h20, 32'hFFFF5A5A, 2'd1, 1'b0);
        // Rejections.
        do_store(32'h21, 32'h12345678, 2'd1, 1'b0);
        do_store(32'h12, 32'h12345678, 2'd2, 1'b0);
        do_store(32'h00, 32'h12345678, 2'd3, 1'b0);

        // Reset during WAIT aborts the byte store.
        req_valid = 1'b1; req_addr = 32'h4; req_data = 32'h000000C3; req_size = 2'd0;
        tick();
        req_valid = 1'b0;
        chk("abort c1 mem_rd", {31'd0, mem_rd}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        chk("abort strobes", {27'd0, mem_rd, mem_wr, done, err, req_ready}, 32'd0);
        tick();
        chk("abort held strobes", {27'd0, mem_rd, mem_wr, done, err, req_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort ram untouched", ram[1], exp_ram[1]);
        chk("abort write count", wr_cnt, exp_wr);
        do_store(32'h8, 32'h1, 2'd2, 1'b0);

        // Back-to-back with req_valid held across both requests.
        nxt_addr = 32'h8; nxt_data = 32'h0BADF00D; nxt_size = 2'd2;
        do_store(32'h1, $urandom, 2'd0, 1'b1);
        do_store(32'h8, 32'h0BADF00D, 2'd2, 1'b0);

        // All four byte lanes, chained back-to-back.
        for (int k = 0; k < 4; k++) begin
            nxt_addr = 32'h40 + 32'(k + 1); nxt_data = $urandom; nxt_size = 2'd0;
            do_store(32'h40 + 32'(k), (k == 0) ? $urandom : req_data, 2'd0, k < 3);
        end

        // Randomized mix, including misaligned and reserved sizes.
        for (int i = 0; i < 80; i++)
            do_store(32'($urandom_range(0, 255)), $urandom, 2'($urandom_range(0, 3)), 1'b0);

        chk("total writes", wr_cnt, exp_wr);
        for (int i = 0; i < 64; i++) chk($sformatf("final ram %0d", i), ram[i], exp_ram[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
